pipeline_ctrl_fsm: RTL and testbench

// - Parametrised pipeline control unit; successor to the combinational commit-stage controller.
// - Turns per-stage pause requests into a prefix pause mask.
// - Priority-encodes N commit-stage exception sources and detects interrupts, using CSR values

---
 rtl/pipeline_ctrl_fsm_pkg.sv | 29 ++
 rtl/pipeline_ctrl_fsm_exc_prio_enc.sv | 31 +++
 rtl/pipeline_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_pipeline_ctrl_fsm.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_fsm_pkg.sv
// Shared types and constants for the commit-stage pipeline controller.
package pipeline_ctrl_fsm_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CSR_ADDR_W = 14;

    // CSR addresses watched for write-forwarding from WB
    localparam logic [CSR_ADDR_W-1:0] CSR_CRMD   = 14'h000;
    localparam logic [CSR_ADDR_W-1:0] CSR_ECFG   = 14'h004;
    localparam logic [CSR_ADDR_W-1:0] CSR_ESTAT  = 14'h005;
    localparam logic [CSR_ADDR_W-1:0] CSR_ERA    = 14'h006;
    localparam logic [CSR_ADDR_W-1:0] CSR_EENTRY = 14'h00C;

    localparam int unsigned CRMD_IE_BIT = 2;
    localparam int unsigned CAUSE_INT   = 0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        IDLE_WAIT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic                  we;
        logic [CSR_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
    } csr_fwd_t;

endpackage

// File: rtl/pipeline_ctrl_fsm_exc_prio_enc.sv
// Priority select of an exception cause: the highest-index set source wins.
module exc_prio_enc #(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned CAUSE_W = 7
) (
    input  logic [NUM_SRC-1:0]         is_exc,
    input  logic [NUM_SRC*CAUSE_W-1:0] cause_vec,
    output logic                       any_c,
    output logic [CAUSE_W-1:0]         cause_c
);

    logic [NUM_SRC-1:0] sel;
    logic               higher;

    // Onehot select, then an AND-OR mux of the chosen cause
    always_comb begin
        sel     = '0;
        higher  = 1'b0;
        cause_c = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            sel[i] = is_exc[i] & ~higher;
            higher = higher | is_exc[i];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            cause_c = cause_c | ({CAUSE_W{sel[i]}} & cause_vec[i*CAUSE_W +: CAUSE_W]);
        end
    end

    assign any_c = |is_exc;

endmodule

// File: rtl/pipeline_ctrl_fsm.sv
// Commit-stage pipeline control: pause mask, exception/interrupt reporting,
// multi-cycle flush with PC redirect, and IDLE wake-up.
module pipeline_ctrl_fsm
    import pipeline_ctrl_fsm_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 7,
    parameter int unsigned NUM_EXC_SRC = 6,
    parameter int unsigned NUM_INT     = 12,
    parameter int unsigned CAUSE_W     = 7,
    parameter int unsigned FLUSH_HOLD  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_STAGES-1:0]          pause_req,
    input  logic                           commit_valid,
    input  logic [XLEN-1:0]                commit_pc,
    input  logic [NUM_EXC_SRC-1:0]         commit_is_exc,
    input  logic [NUM_EXC_SRC*CAUSE_W-1:0] commit_cause,
    input  logic [XLEN-1:0]                commit_exc_addr,
    input  logic                           commit_is_ertn,
    input  logic                           commit_is_idle,
    input  logic [XLEN-1:0]                csr_era,
    input  logic [XLEN-1:0]                csr_eentry,
    input  logic [NUM_INT-1:0]             csr_lie,
    input  logic [NUM_INT-1:0]             csr_is,
    input  logic                           csr_ie,
    input  logic                           fwd_csr_we,
    input  logic [CSR_ADDR_W-1:0]          fwd_csr_addr,
    input  logic [XLEN-1:0]                fwd_csr_wdata,
    output logic [NUM_STAGES-1:0]          pause_o,
    output logic                           flush_o,
    output logic                           redirect_valid,
    output logic [XLEN-1:0]                redirect_pc,
    output logic                           exc_valid,
    output logic [CAUSE_W-1:0]             exc_cause,
    output logic [XLEN-1:0]                exc_pc,
    output logic [XLEN-1:0]                exc_addr,
    output logic                           int_pending
);

    localparam int unsigned CNT_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    ctrl_state_t        state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               flush_n, redirect_valid_n;
    logic [XLEN-1:0]    redirect_pc_n;
    logic               take_flush;
    logic [XLEN-1:0]    flush_target;

    csr_fwd_t           fwd;
    logic [XLEN-1:0]    era_cur, eentry_cur;
    logic [NUM_INT-1:0] lie_cur, is_cur, fwd_int_field;
    logic               ie_cur;

    logic [NUM_STAGES-1:0] pause_prefix;
    logic                  enc_any;
    logic [CAUSE_W-1:0]    enc_cause;

    // CSR view seen by this cycle's commit, including the WB write in flight
    assign fwd           = '{we: fwd_csr_we, addr: fwd_csr_addr, wdata: fwd_csr_wdata};
    assign fwd_int_field = NUM_INT'({fwd.wdata[12:11], fwd.wdata[9:0]});
    assign era_cur       = (fwd.we && fwd.addr == CSR_ERA)    ? fwd.wdata     : csr_era;
    assign eentry_cur    = (fwd.we && fwd.addr == CSR_EENTRY) ? fwd.wdata     : csr_eentry;
    assign lie_cur       = (fwd.we && fwd.addr == CSR_ECFG)   ? fwd_int_field : csr_lie;
    assign is_cur        = (fwd.we && fwd.addr == CSR_ESTAT)  ? fwd_int_field : csr_is;
    assign ie_cur        = (fwd.we && fwd.addr == CSR_CRMD)   ? fwd.wdata[CRMD_IE_BIT] : csr_ie;
    assign int_pending   = ie_cur & (|(lie_cur & is_cur));

    exc_prio_enc #(
        .NUM_SRC (NUM_EXC_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_exc_prio_enc (
        .is_exc    (commit_is_exc),
        .cause_vec (commit_cause),
        .any_c     (enc_any),
        .cause_c   (enc_cause)
    );

    // A stage pauses when it or any later stage requests a pause
    always_comb begin
        pause_prefix = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            pause_prefix[i] = |(pause_req >> i);
        end
    end

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        flush_n          = 1'b0;
        redirect_valid_n = 1'b0;
        redirect_pc_n    = redirect_pc;
        take_flush       = 1'b0;
        flush_target     = eentry_cur;
        exc_valid        = 1'b0;
        exc_cause        = '0;
        exc_pc           = commit_pc;
        exc_addr         = commit_exc_addr;
        pause_o          = pause_prefix;

        case (state)
            RUN: begin
                if (commit_valid) begin
                    if (int_pending) begin
                        exc_valid  = 1'b1;
                        exc_cause  = CAUSE_W'(CAUSE_INT);
                        take_flush = 1'b1;
                    end else if (enc_any) begin
                        exc_valid  = 1'b1;
                        exc_cause  = enc_cause;
                        take_flush = 1'b1;
                    end else if (commit_is_ertn) begin
                        flush_target = era_cur;
                        take_flush   = 1'b1;
                    end else if (commit_is_idle) begin
                        state_n = IDLE_WAIT;
                    end
                end
            end
            FLUSH: begin
                pause_o = '0;
                if (cnt == '0) begin
                    state_n = RUN;
                end else begin
                    cnt_n   = cnt - CNT_W'(1);
                    flush_n = 1'b1;
                end
            end
            IDLE_WAIT: begin
                pause_o = {1'b0, {(NUM_STAGES-1){1'b1}}};
                // Wake-up resumes after the IDLE instruction
                if (int_pending) begin
                    exc_valid  = 1'b1;
                    exc_cause  = CAUSE_W'(CAUSE_INT);
                    exc_pc     = commit_pc + XLEN'(4);
                    take_flush = 1'b1;
                end
            end
            default: state_n = RUN;
        endcase

        if (take_flush) begin
            state_n          = FLUSH;
            cnt_n            = CNT_W'(FLUSH_HOLD - 1);
            flush_n          = 1'b1;
            redirect_valid_n = 1'b1;
            redirect_pc_n    = flush_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            cnt            <= '0;
            flush_o        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            flush_o        <= flush_n;
            redirect_valid <= redirect_valid_n;
            redirect_pc    <= redirect_pc_n;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl_fsm.sv
// Self-checking bench for pipeline_ctrl_fsm: directed scenarios plus random traffic vs a behavioural model.
module tb_pipeline_ctrl_fsm;

    localparam int NS   = 7;
    localparam int NE   = 6;
    localparam int NI   = 12;
    localparam int CW   = 7;
    localparam int HOLD = 3;
    localparam int CV_W = NE * CW;
    localparam int NS1  = NS + 1;

    logic            clk, rst_n;
    logic [NS-1:0]   pause_req;
    logic            commit_valid;
    logic [31:0]     commit_pc;
    logic [NE-1:0]   commit_is_exc;
    logic [CV_W-1:0] commit_cause;
    logic [31:0]     commit_exc_addr;
    logic            commit_is_ertn, commit_is_idle;
    logic [31:0]     csr_era, csr_eentry;
    logic [NI-1:0]   csr_lie, csr_is;
    logic            csr_ie;
    logic            fwd_csr_we;
    logic [13:0]     fwd_csr_addr;
    logic [31:0]     fwd_csr_wdata;
    logic [NS-1:0]   pause_o;
    logic            flush_o, redirect_valid;
    logic [31:0]     redirect_pc;
    logic            exc_valid;
    logic [CW-1:0]   exc_cause;
    logic [31:0]     exc_pc, exc_addr;
    logic            int_pending;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl_fsm #(
        .NUM_STAGES (NS), .NUM_EXC_SRC (NE), .NUM_INT (NI), .CAUSE_W (CW), .FLUSH_HOLD (HOLD)
    ) dut (
        .clk (clk), .rst_n (rst_n), .pause_req (pause_req),
        .commit_valid (commit_valid), .commit_pc (commit_pc), .commit_is_exc (commit_is_exc),
        .commit_cause (commit_cause), .commit_exc_addr (commit_exc_addr),
        .commit_is_ertn (commit_is_ertn), .commit_is_idle (commit_is_idle),
        .csr_era (csr_era), .csr_eentry (csr_eentry), .csr_lie (csr_lie), .csr_is (csr_is),
        .csr_ie (csr_ie), .fwd_csr_we (fwd_csr_we), .fwd_csr_addr (fwd_csr_addr),
        .fwd_csr_wdata (fwd_csr_wdata), .pause_o (pause_o), .flush_o (flush_o),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc), .exc_valid (exc_valid),
        .exc_cause (exc_cause), .exc_pc (exc_pc), .exc_addr (exc_addr), .int_pending (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Prefix mask: ones from bit 0 up to the highest requesting stage
    function automatic logic [NS-1:0] exp_pause(input logic [NS-1:0] req);
        int k = -1;
        logic [NS:0] t;
        for (int i = 0; i < NS; i++) if (req[i]) k = i;
        if (k < 0) return '0;
        t = NS1'(1) << (k + 1);
        return NS'(t - NS1'(1));
    endfunction

    function automatic logic [CW-1:0] exp_cause(input logic [NE-1:0] exc, input logic [CV_W-1:0] causes);
        logic [CW-1:0] c = '0;
        for (int i = 0; i < NE; i++) if (exc[i]) c = causes[i*CW +: CW];
        return c;
    endfunction

    task automatic drive_quiet();
        pause_req = '0; commit_valid = 1'b0; commit_pc = '0; commit_is_exc = '0;
        commit_cause = '0; commit_exc_addr = '0; commit_is_ertn = 1'b0; commit_is_idle = 1'b0;
        csr_era = '0; csr_eentry = '0; csr_lie = '0; csr_is = '0; csr_ie = 1'b0;
        fwd_csr_we = 1'b0; fwd_csr_addr = '0; fwd_csr_wdata = '0;
    endtask

    task automatic apply_reset();
        drive_quiet();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive_quiet();
        rst_n = 1'b0;
        #3;
        total++; if (pause_o !== '0) begin bad++; $display("FAIL reset_pause got=%b want=0", pause_o); end
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush_o); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b want=0", redirect_valid); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h want=0", redirect_pc); end
        total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b want=0", exc_valid); end
        apply_reset();
    endtask

    task automatic test_pause();
        logic [NS-1:0] r;
        pause_req = 7'b0010100; #1;
        total++; if (pause_o !== 7'b0011111) begin bad++; $display("FAIL pause_dir got=%b want=0011111", pause_o); end
        pause_req = '0; #1;
        total++; if (pause_o !== '0) begin bad++; $display("FAIL pause_zero got=%b want=0", pause_o); end
        for (int n = 0; n < 16; n++) begin
            r = NS'($urandom);
            pause_req = r; #1;
            total++; if (pause_o !== exp_pause(r)) begin bad++; $display("FAIL pause_rand req=%b got=%b want=%b", r, pause_o, exp_pause(r)); end
        end
        pause_req = '0;
    endtask

    task automatic test_exception();
        drive_quiet();
        commit_valid = 1'b1; commit_pc = 32'h0000_1234; commit_exc_addr = 32'hDEAD_BEE0;
        commit_cause = CV_W'({$urandom(), $urandom()});
        commit_cause[1*CW +: CW] = 7'h08;
        commit_cause[4*CW +: CW] = 7'h0B;
        commit_is_exc = 6'b010010;
        csr_eentry = 32'h1C00_8000; csr_era = 32'h0000_0100;
        #1;
        total++; if (exc_valid !== 1'b1) begin bad++; $display("FAIL exc_valid got=%b want=1", exc_valid); end
        total++; if (exc_cause !== 7'h0B) begin bad++; $display("FAIL exc_cause got=%h want=0b", exc_cause); end
        total++; if (exc_pc !== 32'h0000_1234) begin bad++; $display("FAIL exc_pc got=%h want=00001234", exc_pc); end
        total++; if (exc_addr !== 32'hDEAD_BEE0) begin bad++; $display("FAIL exc_addr got=%h want=deadbee0", exc_addr); end
        @(posedge clk); #1;
        // New exception and pause requests arrive while flushing and must be ignored
        commit_is_exc = 6'b000001; commit_cause = CV_W'(7'h11); pause_req = 7'h7F;
        for (int c = 0; c < HOLD; c++) begin
            #1;
            total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL flush_hold c=%0d got=%b want=1", c, flush_o); end
            total++; if (redirect_valid !== (c == 0)) begin bad++; $display("FAIL rv_pulse c=%0d got=%b want=%b", c, redirect_valid, c == 0); end
            total++; if (redirect_pc !== 32'h1C00_8000) begin bad++; $display("FAIL rpc_exc got=%h want=1c008000", redirect_pc); end
            total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL squash c=%0d got=%b want=0", c, exc_valid); end
            total++; if (pause_o !== '0) begin bad++; $display("FAIL flush_pause got=%b want=0", pause_o); end
            @(posedge clk); #1;
        end
        drive_quiet(); #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL flush_end got=%b want=0", flush_o); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rv_end got=%b want=0", redirect_valid); end
    endtask

    task automatic test_ertn();
        drive_quiet();
        commit_valid = 1'b1; commit_is_ertn = 1'b1; csr_era = 32'h0000_0100;
        fwd_csr_we = 1'b1; fwd_csr_addr = 14'h006; fwd_csr_wdata = 32'h0000_0200;
        #1;
        total++; if (exc_valid !== 1'b0) begin bad++; $display("FAIL ertn_exc got=%b want=0", exc_valid); end
        @(posedge clk); #1;
        drive_quiet(); #1;
        total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL ertn_rv got=%b want=1", redirect_valid); end
        total++; if (redirect_pc !== 32'h0000_0200) begin bad++; $display("FAIL ertn_rpc got=%h want=00000200", redirect_pc); end
        repeat (HOLD) @(posedge clk);
        #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL ertn_done got=%b want=0", flush_o); end
    endtask

    task automatic test_idle();
        drive_quiet();
        commit_valid = 1'b1; commit_is_idle = 1'b1; commit_pc = 32'h0000_0040;
        csr_ie = 1'b0; csr_lie = 12'h001; csr_is = 12'h001; csr_eentry = 32'h1C00_8000;
        #1;
        total++; if (int_pending !== 1'b0) begin bad++; $display("FAIL idle_nopend got=%b want=0", int_pending); end
        @(posedge clk); #1;
        pause_req = 7'b1000000;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (pause_o !== 7'b0111111) begin bad++; $display("FAIL idle_pause got=%b want=0111111", pause_o); end
            total++; if (exc_valid !== 1'b0 || flush_o !== 1'b0) begin bad++; $display("FAIL idle_quiet exc=%b flush=%b want=0,0", exc_valid, flush_o); end
            @(posedge clk); #1;
        end
        fwd_csr_we = 1'b1; fwd_csr_addr = 14'h000; fwd_csr_wdata = 32'h0000_0004;
        #1;
        total++; if (int_pending !== 1'b1) begin bad++; $display("FAIL wake_pend got=%b want=1", int_pending); end
        total++; if (exc_valid !== 1'b1) begin bad++; $display("FAIL wake_exc got=%b want=1", exc_valid); end
        total++; if (exc_cause !== 7'h00) begin bad++; $display("FAIL wake_cause got=%h want=00", exc_cause); end
        total++; if (exc_pc !== 32'h0000_0044) begin bad++; $display("FAIL wake_pc got=%h want=00000044", exc_pc); end
        @(posedge clk); #1;
        drive_quiet(); #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL wake_flush got=%b want=1", flush_o); end
        total++; if (redirect_pc !== 32'h1C00_8000) begin bad++; $display("FAIL wake_rpc got=%h want=1c008000", redirect_pc); end
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_flush();
        drive_quiet();
        commit_valid = 1'b1; commit_is_exc = 6'b000100; csr_eentry = 32'h0000_8000;
        @(posedge clk); #1;
        drive_quiet(); #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL rmf_pre got=%b want=1", flush_o); end
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL rmf_flush got=%b want=0", flush_o); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rmf_rv got=%b want=0", redirect_valid); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        pause_req = 7'b0010100; #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL rmf_after got=%b want=0", flush_o); end
        total++; if (pause_o !== 7'b0011111) begin bad++; $display("FAIL rmf_run got=%b want=0011111", pause_o); end
        pause_req = '0;
    endtask

    task automatic test_random();
        bit          flush_q[$];
        bit          m_idle = 1'b0;
        logic        m_rv = 1'b0;
        logic [31:0] m_rpc = '0;
        logic [13:0] addrs [6];
        logic [31:0] era_e, eentry_e, epc, tgt;
        logic [NI-1:0] lie_e, is_e;
        logic        ie_e, int_p, busy, ev, ev_exc, wake, go_idle;
        logic [CW-1:0] ecause;
        logic [NS-1:0] epause;
        addrs[0] = 14'h000; addrs[1] = 14'h004; addrs[2] = 14'h005;
        addrs[3] = 14'h006; addrs[4] = 14'h00C; addrs[5] = 14'h123;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            commit_valid    = ($urandom_range(0, 9) < 7);
            pause_req       = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            commit_pc       = $urandom & 32'hFFFF_FFFC;
            commit_exc_addr = $urandom;
            commit_is_exc   = ($urandom_range(0, 4) == 0) ? NE'($urandom) : '0;
            commit_cause    = CV_W'({$urandom(), $urandom()});
            commit_is_ertn  = ($urandom_range(0, 5) == 0);
            commit_is_idle  = ($urandom_range(0, 5) == 0);
            csr_era         = $urandom;
            csr_eentry      = $urandom;
            csr_lie         = NI'($urandom);
            csr_is          = ($urandom_range(0, 3) == 0) ? NI'($urandom & $urandom) : '0;
            csr_ie          = ($urandom_range(0, 2) == 0);
            fwd_csr_we      = ($urandom_range(0, 3) == 0);
            fwd_csr_addr    = addrs[$urandom_range(0, 5)];
            fwd_csr_wdata   = $urandom;
            #1;
            era_e    = (fwd_csr_we && fwd_csr_addr == 14'h006) ? fwd_csr_wdata : csr_era;
            eentry_e = (fwd_csr_we && fwd_csr_addr == 14'h00C) ? fwd_csr_wdata : csr_eentry;
            lie_e    = (fwd_csr_we && fwd_csr_addr == 14'h004) ? {fwd_csr_wdata[12:11], fwd_csr_wdata[9:0]} : csr_lie;
            is_e     = (fwd_csr_we && fwd_csr_addr == 14'h005) ? {fwd_csr_wdata[12:11], fwd_csr_wdata[9:0]} : csr_is;
            ie_e     = (fwd_csr_we && fwd_csr_addr == 14'h000) ? fwd_csr_wdata[2] : csr_ie;
            int_p    = ie_e && ((lie_e & is_e) != '0);
            busy     = (flush_q.size() != 0);
            ev = 1'b0; ev_exc = 1'b0; wake = 1'b0; go_idle = 1'b0;
            ecause = '0; epc = commit_pc; tgt = eentry_e;
            if (busy)        epause = '0;
            else if (m_idle) epause = 7'b0111111;
            else             epause = exp_pause(pause_req);
            if (!busy && m_idle) begin
                if (int_p) begin ev = 1'b1; ev_exc = 1'b1; wake = 1'b1; epc = commit_pc + 32'd4; end
            end else if (!busy && commit_valid) begin
                if (int_p)                    begin ev = 1'b1; ev_exc = 1'b1; end
                else if (commit_is_exc != '0) begin ev = 1'b1; ev_exc = 1'b1; ecause = exp_cause(commit_is_exc, commit_cause); end
                else if (commit_is_ertn)      begin ev = 1'b1; tgt = era_e; end
                else if (commit_is_idle)      go_idle = 1'b1;
            end
            total++; if (pause_o !== epause) begin bad++; $display("FAIL rnd_pause n=%0d got=%b want=%b", n, pause_o, epause); end
            total++; if (int_pending !== int_p) begin bad++; $display("FAIL rnd_intp n=%0d got=%b want=%b", n, int_pending, int_p); end
            total++; if (exc_valid !== ev_exc) begin bad++; $display("FAIL rnd_excv n=%0d got=%b want=%b", n, exc_valid, ev_exc); end
            if (ev_exc) begin
                total++; if (exc_cause !== ecause) begin bad++; $display("FAIL rnd_cause n=%0d got=%h want=%h", n, exc_cause, ecause); end
                total++; if (exc_pc !== epc) begin bad++; $display("FAIL rnd_epc n=%0d got=%h want=%h", n, exc_pc, epc); end
                if (!wake) begin
                    total++; if (exc_addr !== commit_exc_addr) begin bad++; $display("FAIL rnd_eaddr n=%0d got=%h want=%h", n, exc_addr, commit_exc_addr); end
                end
            end
            total++; if (flush_o !== busy) begin bad++; $display("FAIL rnd_flush n=%0d got=%b want=%b", n, flush_o, busy); end
            total++; if (redirect_valid !== m_rv) begin bad++; $display("FAIL rnd_rv n=%0d got=%b want=%b", n, redirect_valid, m_rv); end
            total++; if (redirect_pc !== m_rpc) begin bad++; $display("FAIL rnd_rpc n=%0d got=%h want=%h", n, redirect_pc, m_rpc); end
            if (busy) void'(flush_q.pop_front());
            m_rv = 1'b0;
            if (ev) begin
                for (int h = 0; h < HOLD; h++) flush_q.push_back(1'b1);
                m_rv = 1'b1; m_rpc = tgt; m_idle = 1'b0;
            end
            if (go_idle) m_idle = 1'b1;
            @(posedge clk); #1;
        end
        drive_quiet();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_quiet();
        test_reset();
        test_pause();
        apply_reset();
        test_exception();
        apply_reset();
        test_ertn();
        apply_reset();
        test_idle();
        apply_reset();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
